// File: rtl/rv32i_ctrl_pkg.sv
// Shared decode constants, control-bundle struct and decode helpers for the RV32I control unit.
// Pure constants and functions: no latency, no flow control.
package rv32i_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_NONE   = 4'b0000;
    localparam logic [3:0] ALU_ADD    = 4'b0001;
    localparam logic [3:0] ALU_SUB    = 4'b0010;
    localparam logic [3:0] ALU_SLT    = 4'b0011;
    localparam logic [3:0] ALU_SLTU   = 4'b0100;
    localparam logic [3:0] ALU_XOR    = 4'b0101;
    localparam logic [3:0] ALU_OR     = 4'b0110;
    localparam logic [3:0] ALU_AND    = 4'b0111;
    localparam logic [3:0] ALU_SLL    = 4'b1000;
    localparam logic [3:0] ALU_SRL    = 4'b1001;
    localparam logic [3:0] ALU_SRA    = 4'b1010;
    localparam logic [3:0] ALU_PASS_B = 4'b1011;

    localparam logic [1:0] WB_NONE = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_MEM  = 2'b10;
    localparam logic [1:0] WB_PC4  = 2'b11;

    localparam logic [2:0] DM_NONE = 3'b000;
    localparam logic [2:0] DM_B    = 3'b001;
    localparam logic [2:0] DM_H    = 3'b010;
    localparam logic [2:0] DM_W    = 3'b011;
    localparam logic [2:0] DM_BU   = 3'b100;
    localparam logic [2:0] DM_HU   = 3'b101;

    typedef struct packed {
        logic       pc_sel;
        logic       rd_wr_en;
        logic       br_unsigned;
        logic       a_sel;
        logic       b_sel;
        logic [3:0] alu_sel;
        logic       mem_wr_en;
        logic [1:0] wb_sel;
        logic [2:0] data_mode;
        logic       instr_vld;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    function automatic logic [2:0] load_mode(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return DM_B;
            3'b001:  return DM_H;
            3'b010:  return DM_W;
            3'b100:  return DM_BU;
            3'b101:  return DM_HU;
            default: return DM_NONE;
        endcase
    endfunction

    function automatic logic [2:0] store_mode(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return DM_B;
            3'b001:  return DM_H;
            3'b010:  return DM_W;
            default: return DM_NONE;
        endcase
    endfunction

    // ALU_NONE marks an illegal funct3/funct7 pairing; OP-IMM ignores funct7 except on shifts.
    function automatic logic [3:0] arith_alu(input logic [2:0] funct3,
                                             input logic [6:0] funct7,
                                             input logic       is_imm);
        logic plain_ok;
        plain_ok = is_imm || (funct7 == F7_BASE);
        case (funct3)
            3'b000:  return plain_ok ? ALU_ADD : ((funct7 == F7_ALT) ? ALU_SUB : ALU_NONE);
            3'b001:  return (funct7 == F7_BASE) ? ALU_SLL : ALU_NONE;
            3'b010:  return plain_ok ? ALU_SLT  : ALU_NONE;
            3'b011:  return plain_ok ? ALU_SLTU : ALU_NONE;
            3'b100:  return plain_ok ? ALU_XOR  : ALU_NONE;
            3'b101:  return (funct7 == F7_BASE) ? ALU_SRL :
                            ((funct7 == F7_ALT) ? ALU_SRA : ALU_NONE);
            3'b110:  return plain_ok ? ALU_OR  : ALU_NONE;
            default: return plain_ok ? ALU_AND : ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_branch_resolve.sv
// Branch condition evaluation from funct3 and comparator flags.
// Latency: 0 cycles (combinational); no backpressure.
module rv32i_branch_resolve
    import rv32i_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       br_less,
    input  logic       br_equal,
    output logic       taken,
    output logic       br_unsigned
);

    always_comb begin
        taken       = 1'b0;
        br_unsigned = (funct3[2:1] == 2'b11);
        case (funct3)
            3'b000:         taken = br_equal;
            3'b001:         taken = !br_equal;
            3'b100, 3'b110: taken = br_less;
            3'b101, 3'b111: taken = !br_less;
            default:        taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32i_control_unit.sv
// Main RV32I instruction decoder producing all datapath controls.
// Latency: 0 cycles (combinational); no backpressure, side effects held off until first edge out of reset.
module rv32i_control_unit
    import rv32i_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        br_less,
    input  logic        br_equal,
    output logic        br_unsigned,
    output logic        mem_wr_en,
    output logic        rd_wr_en,
    output logic        pc_sel,
    output logic        a_sel,
    output logic        b_sel,
    output logic [1:0]  wb_sel,
    output logic [2:0]  data_mode,
    output logic [3:0]  alu_sel,
    output logic        instr_vld
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       run_q;
    logic       br_taken;
    logic       br_uns;
    logic [3:0] arith_op;
    logic [2:0] ld_mode;
    logic [2:0] st_mode;
    logic       unused_bits;
    ctrl_t      dec;
    ctrl_t      ctrl;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    assign unused_bits = ^{instr[24:15], instr[11:7]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    rv32i_branch_resolve u_branch (
        .funct3      (funct3),
        .br_less     (br_less),
        .br_equal    (br_equal),
        .taken       (br_taken),
        .br_unsigned (br_uns)
    );

    assign arith_op = arith_alu(funct3, funct7, opcode == OPC_OP_IMM);
    assign ld_mode  = load_mode(funct3);
    assign st_mode  = store_mode(funct3);

    always_comb begin
        dec = CTRL_NONE;
        case (opcode)
            OPC_LUI: begin
                dec.rd_wr_en  = 1'b1;
                dec.b_sel     = 1'b1;
                dec.alu_sel   = ALU_PASS_B;
                dec.wb_sel    = WB_ALU;
                dec.instr_vld = 1'b1;
            end
            OPC_AUIPC: begin
                dec.rd_wr_en  = 1'b1;
                dec.a_sel     = 1'b1;
                dec.b_sel     = 1'b1;
                dec.alu_sel   = ALU_ADD;
                dec.wb_sel    = WB_ALU;
                dec.instr_vld = 1'b1;
            end
            OPC_JAL: begin
                dec.pc_sel    = 1'b1;
                dec.rd_wr_en  = 1'b1;
                dec.a_sel     = 1'b1;
                dec.b_sel     = 1'b1;
                dec.alu_sel   = ALU_ADD;
                dec.wb_sel    = WB_PC4;
                dec.instr_vld = 1'b1;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    dec.pc_sel    = 1'b1;
                    dec.rd_wr_en  = 1'b1;
                    dec.b_sel     = 1'b1;
                    dec.alu_sel   = ALU_ADD;
                    dec.wb_sel    = WB_PC4;
                    dec.instr_vld = 1'b1;
                end
            end
            OPC_BRANCH: begin
                // funct3 010/011 are unassigned branch encodings
                if (funct3[2] || !funct3[1]) begin
                    dec.pc_sel      = br_taken;
                    dec.br_unsigned = br_uns;
                    dec.a_sel       = 1'b1;
                    dec.b_sel       = 1'b1;
                    dec.alu_sel     = ALU_ADD;
                    dec.instr_vld   = 1'b1;
                end
            end
            OPC_LOAD: begin
                if (ld_mode != DM_NONE) begin
                    dec.rd_wr_en  = 1'b1;
                    dec.b_sel     = 1'b1;
                    dec.alu_sel   = ALU_ADD;
                    dec.wb_sel    = WB_MEM;
                    dec.data_mode = ld_mode;
                    dec.instr_vld = 1'b1;
                end
            end
            OPC_STORE: begin
                if (st_mode != DM_NONE) begin
                    dec.b_sel     = 1'b1;
                    dec.alu_sel   = ALU_ADD;
                    dec.mem_wr_en = 1'b1;
                    dec.data_mode = st_mode;
                    dec.instr_vld = 1'b1;
                end
            end
            OPC_OP_IMM, OPC_OP: begin
                if (arith_op != ALU_NONE) begin
                    dec.rd_wr_en  = 1'b1;
                    dec.b_sel     = (opcode == OPC_OP_IMM);
                    dec.alu_sel   = arith_op;
                    dec.wb_sel    = WB_ALU;
                    dec.instr_vld = 1'b1;
                end
            end
            default: dec = CTRL_NONE;
        endcase
    end

    always_comb begin
        ctrl = dec;
        if (!run_q) begin
            ctrl.pc_sel    = 1'b0;
            ctrl.rd_wr_en  = 1'b0;
            ctrl.mem_wr_en = 1'b0;
            ctrl.instr_vld = 1'b0;
        end
    end

    assign pc_sel      = ctrl.pc_sel;
    assign rd_wr_en    = ctrl.rd_wr_en;
    assign br_unsigned = ctrl.br_unsigned;
    assign a_sel       = ctrl.a_sel;
    assign b_sel       = ctrl.b_sel;
    assign alu_sel     = ctrl.alu_sel;
    assign mem_wr_en   = ctrl.mem_wr_en;
    assign wb_sel      = ctrl.wb_sel;
    assign data_mode   = ctrl.data_mode;
    assign instr_vld   = ctrl.instr_vld;

endmodule

// File: tb/tb_rv32i_control_unit.sv
// Directed and exhaustive-decode checks for rv32i_control_unit.
module tb_rv32i_control_unit;

    logic        clk;
    logic        clk_on;
    logic        rst_n;
    logic [31:0] instr;
    logic        br_less;
    logic        br_equal;
    logic        br_unsigned;
    logic        mem_wr_en;
    logic        rd_wr_en;
    logic        pc_sel;
    logic        a_sel;
    logic        b_sel;
    logic [1:0]  wb_sel;
    logic [2:0]  data_mode;
    logic [3:0]  alu_sel;
    logic        instr_vld;
    logic [15:0] obs;

    int n_checks = 0;
    int n_errors = 0;

    rv32i_control_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .br_less     (br_less),
        .br_equal    (br_equal),
        .br_unsigned (br_unsigned),
        .mem_wr_en   (mem_wr_en),
        .rd_wr_en    (rd_wr_en),
        .pc_sel      (pc_sel),
        .a_sel       (a_sel),
        .b_sel       (b_sel),
        .wb_sel      (wb_sel),
        .data_mode   (data_mode),
        .alu_sel     (alu_sel),
        .instr_vld   (instr_vld)
    );

    // {pc_sel, rd_wr_en, br_unsigned, a_sel, b_sel, alu_sel, mem_wr_en, wb_sel, data_mode, instr_vld}
    assign obs = {pc_sel, rd_wr_en, br_unsigned, a_sel, b_sel, alu_sel,
                  mem_wr_en, wb_sel, data_mode, instr_vld};

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_on) clk = ~clk;
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] row(input logic pc, input logic rd, input logic bu,
                                        input logic a, input logic b, input logic [3:0] alu,
                                        input logic mw, input logic [1:0] wb,
                                        input logic [2:0] dm);
        return {pc, rd, bu, a, b, alu, mw, wb, dm, 1'b1};
    endfunction

    function automatic logic [15:0] golden(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic lt,
                                           input logic eq);
        logic [15:0] g;
        g = '0;
        case (op)
            7'b0110111: g = row(0, 1, 0, 0, 1, 4'd11, 0, 2'b01, 3'd0);
            7'b0010111: g = row(0, 1, 0, 1, 1, 4'd1, 0, 2'b01, 3'd0);
            7'b1101111: g = row(1, 1, 0, 1, 1, 4'd1, 0, 2'b11, 3'd0);
            7'b1100111: if (f3 == 3'd0) g = row(1, 1, 0, 0, 1, 4'd1, 0, 2'b11, 3'd0);
            7'b1100011: case (f3)
                3'd0: g = row(eq,  0, 0, 1, 1, 4'd1, 0, 2'b00, 3'd0);
                3'd1: g = row(!eq, 0, 0, 1, 1, 4'd1, 0, 2'b00, 3'd0);
                3'd4: g = row(lt,  0, 0, 1, 1, 4'd1, 0, 2'b00, 3'd0);
                3'd5: g = row(!lt, 0, 0, 1, 1, 4'd1, 0, 2'b00, 3'd0);
                3'd6: g = row(lt,  0, 1, 1, 1, 4'd1, 0, 2'b00, 3'd0);
                3'd7: g = row(!lt, 0, 1, 1, 1, 4'd1, 0, 2'b00, 3'd0);
                default: g = '0;
            endcase
            7'b0000011: case (f3)
                3'd0: g = row(0, 1, 0, 0, 1, 4'd1, 0, 2'b10, 3'd1);
                3'd1: g = row(0, 1, 0, 0, 1, 4'd1, 0, 2'b10, 3'd2);
                3'd2: g = row(0, 1, 0, 0, 1, 4'd1, 0, 2'b10, 3'd3);
                3'd4: g = row(0, 1, 0, 0, 1, 4'd1, 0, 2'b10, 3'd4);
                3'd5: g = row(0, 1, 0, 0, 1, 4'd1, 0, 2'b10, 3'd5);
                default: g = '0;
            endcase
            7'b0100011: case (f3)
                3'd0: g = row(0, 0, 0, 0, 1, 4'd1, 1, 2'b00, 3'd1);
                3'd1: g = row(0, 0, 0, 0, 1, 4'd1, 1, 2'b00, 3'd2);
                3'd2: g = row(0, 0, 0, 0, 1, 4'd1, 1, 2'b00, 3'd3);
                default: g = '0;
            endcase
            7'b0010011: case (f3)
                3'd0: g = row(0, 1, 0, 0, 1, 4'd1, 0, 2'b01, 3'd0);
                3'd2: g = row(0, 1, 0, 0, 1, 4'd3, 0, 2'b01, 3'd0);
                3'd3: g = row(0, 1, 0, 0, 1, 4'd4, 0, 2'b01, 3'd0);
                3'd4: g = row(0, 1, 0, 0, 1, 4'd5, 0, 2'b01, 3'd0);
                3'd6: g = row(0, 1, 0, 0, 1, 4'd6, 0, 2'b01, 3'd0);
                3'd7: g = row(0, 1, 0, 0, 1, 4'd7, 0, 2'b01, 3'd0);
                3'd1: if (f7 == 7'h00) g = row(0, 1, 0, 0, 1, 4'd8, 0, 2'b01, 3'd0);
                default: begin
                    if (f7 == 7'h00) g = row(0, 1, 0, 0, 1, 4'd9, 0, 2'b01, 3'd0);
                    if (f7 == 7'h20) g = row(0, 1, 0, 0, 1, 4'd10, 0, 2'b01, 3'd0);
                end
            endcase
            7'b0110011: case ({f3, f7})
                {3'd0, 7'h00}: g = row(0, 1, 0, 0, 0, 4'd1, 0, 2'b01, 3'd0);
                {3'd0, 7'h20}: g = row(0, 1, 0, 0, 0, 4'd2, 0, 2'b01, 3'd0);
                {3'd1, 7'h00}: g = row(0, 1, 0, 0, 0, 4'd8, 0, 2'b01, 3'd0);
                {3'd2, 7'h00}: g = row(0, 1, 0, 0, 0, 4'd3, 0, 2'b01, 3'd0);
                {3'd3, 7'h00}: g = row(0, 1, 0, 0, 0, 4'd4, 0, 2'b01, 3'd0);
                {3'd4, 7'h00}: g = row(0, 1, 0, 0, 0, 4'd5, 0, 2'b01, 3'd0);
                {3'd5, 7'h00}: g = row(0, 1, 0, 0, 0, 4'd9, 0, 2'b01, 3'd0);
                {3'd5, 7'h20}: g = row(0, 1, 0, 0, 0, 4'd10, 0, 2'b01, 3'd0);
                {3'd6, 7'h00}: g = row(0, 1, 0, 0, 0, 4'd6, 0, 2'b01, 3'd0);
                {3'd7, 7'h00}: g = row(0, 1, 0, 0, 0, 4'd7, 0, 2'b01, 3'd0);
                default: g = '0;
            endcase
            default: g = '0;
        endcase
        return g;
    endfunction

    initial begin
        logic [18:0] key;
        logic [15:0] exp_v;
        clk_on   = 1'b1;
        rst_n    = 1'b0;
        instr    = 32'h003100B3;
        br_less  = 1'b0;
        br_equal = 1'b0;

        // reset held: write enables and valid forced low, decode still visible
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rd_wr_en", {15'd0, rd_wr_en}, 16'd0);
        check("rst_instr_vld", {15'd0, instr_vld}, 16'd0);
        check("rst_alu_sel", {12'd0, alu_sel}, 16'd1);
        rst_n = 1'b1;
        #1;
        check("pre_edge_rd_wr_en", {15'd0, rd_wr_en}, 16'd0);
        @(posedge clk);
        #1;
        check("add_run", obs, 16'b0_1_0_0_0_0001_0_01_000_1);

        @(negedge clk);
        instr = 32'h403100B3;
        #1;
        check("sub_alu_sel", {12'd0, alu_sel}, 16'b0010);
        instr = 32'h40015093;
        #1;
        check("srai", obs, 16'b0_1_0_0_1_1010_0_01_000_1);

        instr = 32'h00007063;
        #1;
        check("bgeu_taken", obs, 16'b1_0_1_1_1_0001_0_00_000_1);
        br_less = 1'b1;
        #1;
        check("bgeu_not_taken_pc", {15'd0, pc_sel}, 16'd0);

        br_less  = 1'b0;
        br_equal = 1'b1;
        instr    = 32'h00000063;
        #1;
        check("beq_taken_pc", {15'd0, pc_sel}, 16'd1);
        instr = 32'h00001063;
        #1;
        check("bne_not_taken_pc", {15'd0, pc_sel}, 16'd0);
        br_equal = 1'b0;

        instr = 32'h00812283;
        #1;
        check("lw", obs, 16'b0_1_0_0_1_0001_0_10_011_1);
        instr = 32'h00000023;
        #1;
        check("sb", obs, 16'b0_0_0_0_1_0001_1_00_001_1);
        instr = 32'h02310033;
        #1;
        check("op_funct7_01_illegal", obs, 16'd0);
        instr = 32'h00006003;
        #1;
        check("load_f3_110_illegal", obs, 16'd0);
        instr = 32'h00002063;
        #1;
        check("branch_f3_010_illegal", obs, 16'd0);

        // mid-run reset lands on the next edge only
        @(negedge clk);
        instr = 32'h00000023;
        rst_n = 1'b0;
        #1;
        check("midrst_before_edge", {15'd0, mem_wr_en}, 16'd1);
        @(posedge clk);
        #1;
        check("midrst_after_edge", obs, 16'b0_0_0_0_1_0001_0_00_001_0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_release", {15'd0, mem_wr_en}, 16'd1);

        // exhaustive decode with the clock parked; unused instruction bits randomised
        @(negedge clk);
        clk_on = 1'b0;
        for (int k = 0; k < (1 << 19); k++) begin
            key      = k[18:0];
            instr    = {key[11:5], 10'($urandom), key[14:12], 5'($urandom), key[18:12] == 7'd0 ? key[18:12] : key[18:12]};
            instr[6:0]   = key[18:12];
            instr[14:12] = key[11:9];
            instr[31:25] = key[8:2];
            br_less  = key[1];
            br_equal = key[0];
            exp_v    = golden(key[18:12], key[11:9], key[8:2], key[1], key[0]);
            #1;
            n_checks++;
            assert (obs === exp_v) else begin
                n_errors++;
                $error("FAIL sweep instr=%08h lt=%0b eq=%0b: observed %0h expected %0h",
                       instr, br_less, br_equal, obs, exp_v);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
